uart_tx_cfg: RTL and testbench

Parametrised UART transmitter and the next-generation successor to the single-format transmitter in the full-duplex UART/LED design. Adds configurable data width and oversampling, and per-frame parity and stop-bit selection. Adds a one-entry holding buffer with a valid/ready handshake, so frames go out back-to-back, plus a break-generation mode. Sits between the host-side byte source and the tx pin, and is driven by the shared baud-tick generator.

---
 rtl/uart_tx_cfg.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DBITS data bits, OSR ticks per bit,
// per-frame parity / stop-bit selection latched with the data word,
// a one-entry holding buffer for back-to-back frames, and line break.
module uart_tx_cfg #(
  parameter int DBITS = 8,
  parameter int OSR   = 16
) (
  input  logic             clk_50Mhz,
  input  logic             rst,
  input  logic             tick,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [DBITS-1:0] din,
  input  logic [1:0]       parity_mode,
  input  logic             two_stop,
  input  logic             brk,
  output logic             tx,
  output logic             tx_busy,
  output logic             frame_done
);

  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int BW = $clog2(DBITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [BW-1:0]      r_bit, w_bit_nxt;
  logic [DBITS-1:0]   r_shift, w_shift_nxt;
  logic               r_par_en, r_par_bit, r_two;
  logic               r_tx, w_tx_nxt;
  logic               r_frame_done;

  // holding buffer entry
  logic               r_buf_full, w_buf_full_nxt;
  logic [DBITS-1:0]   r_buf_data;
  logic [1:0]         r_buf_pm;
  logic               r_buf_two;
  logic               r_din_ready;

  logic w_hs, w_bit_end, w_stop_end, w_load;

  assign w_hs       = din_valid && r_din_ready;
  assign w_bit_end  = tick && (r_cnt == CNT_LAST);
  // r_bit counts stop bits while in STOP
  assign w_stop_end = (r_state == S_STOP) && w_bit_end && (r_bit == BW'(r_two));
  // brk only blocks a load from IDLE; a load at end of STOP ignores it
  assign w_load     = r_buf_full && (((r_state == S_IDLE) && !brk) || w_stop_end);
  assign w_buf_full_nxt = w_load ? 1'b0 : (w_hs ? 1'b1 : r_buf_full);

  assign din_ready  = r_din_ready;
  assign tx         = r_tx;
  assign frame_done = r_frame_done;
  assign tx_busy    = (r_state != S_IDLE) || r_buf_full;

  // next-state, counters and shift register; a load overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    if (tick) w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (brk) w_state_nxt = S_BREAK;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BIT_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_bit_nxt   = '0;
        end
      end
      S_STOP: begin
        if (w_stop_end)     w_state_nxt = S_IDLE;
        else if (w_bit_end) w_bit_nxt   = r_bit + 1'b1;
      end
      S_BREAK: begin
        w_cnt_nxt = '0;
        if (!brk) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_load) begin
      w_state_nxt = S_START;
      w_cnt_nxt   = '0;
      w_bit_nxt   = '0;
      w_shift_nxt = r_buf_data;
    end
  end

  // line level follows the state being entered so tx is registered with it
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START, S_BREAK: w_tx_nxt = 1'b0;
      S_DATA:           w_tx_nxt = w_shift_nxt[0];
      S_PARITY:         w_tx_nxt = r_par_bit;
      default:          w_tx_nxt = 1'b1;
    endcase
  end

  // engine registers and per-frame configuration captured at load
  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_bit    <= 1'b0;
      r_two        <= 1'b0;
      r_tx         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit        <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_tx         <= w_tx_nxt;
      r_frame_done <= w_stop_end;
      if (w_load) begin
        r_par_en  <= (r_buf_pm == 2'b01) || (r_buf_pm == 2'b10);
        r_par_bit <= (^r_buf_data) ^ (r_buf_pm == 2'b10);
        r_two     <= r_buf_two;
      end
    end
  end

  // holding buffer: word, parity mode and stop count travel as one entry
  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      r_buf_full  <= 1'b0;
      r_buf_data  <= '0;
      r_buf_pm    <= 2'b00;
      r_buf_two   <= 1'b0;
      r_din_ready <= 1'b1;
    end else begin
      r_buf_full  <= w_buf_full_nxt;
      r_din_ready <= !w_buf_full_nxt;
      if (w_hs) begin
        r_buf_data <= din;
        r_buf_pm   <= parity_mode;
        r_buf_two  <= two_stop;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg (DBITS=8, OSR=16): table of single
// frames with hand-computed line patterns, plus back-to-back, break and
// mid-frame reset sequences. Inputs driven and outputs sampled on negedge.
module tb_uart_tx_cfg;
  localparam int OSR = 16;

  logic       clk_50Mhz = 1'b0;
  logic       rst, tick, din_valid, din_ready;
  logic [7:0] din;
  logic [1:0] parity_mode;
  logic       two_stop, brk, tx, tx_busy, frame_done;

  int checks = 0;
  int errors = 0;
  int phase  = 0;
  int tdiv   = 1;

  always #10 clk_50Mhz = ~clk_50Mhz;

  uart_tx_cfg #(.DBITS(8), .OSR(OSR)) dut (
    .clk_50Mhz  (clk_50Mhz),
    .rst        (rst),
    .tick       (tick),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din        (din),
    .parity_mode(parity_mode),
    .two_stop   (two_stop),
    .brk        (brk),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .frame_done (frame_done)
  );

  // eb: frame bits, bit 0 = start bit, then data LSB first, parity, stops
  typedef struct {
    logic [7:0]  d;
    logic [1:0]  pm;
    logic        two;
    int          nb;
    logic [11:0] eb;
    int          td;
    string       nm;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_50Mhz);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (din_ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    if (din_ready !== 1'b1) chk({nm, " ready_timeout"}, 0, 1);
  endtask

  // Walk one frame from its first START sample, counting ticks driven.
  // One comparison per bit period: every sample in it must match.
  task automatic check_bits(input logic [11:0] eb, input int nb, input bit fd0,
                            input bit b2b, input string nm);
    int nt = 0;
    int k = 0;
    int fd_seen = 0;
    int obs;
    logic [11:0] e;
    e   = eb;
    obs = int'(e[0]);
    chk({nm, " fd_start"}, int'(frame_done), int'(fd0));
    while (nt < nb * OSR) begin
      if (tx !== e[nt / OSR]) obs = int'(tx);
      if (k > 0 && frame_done === 1'b1) fd_seen++;
      if (b2b && k == 1) begin
        din_valid = 1'b0;
        chk({nm, " accept_in_start"}, int'(din_ready), 0);
      end
      if (k == 40) begin
        two_stop    = ~two_stop;
        parity_mode = ~parity_mode;
      end
      tick  = (phase == 0);
      phase = (phase + 1) % tdiv;
      if (tick) begin
        nt++;
        if (nt % OSR == 0) begin
          chk($sformatf("%s bit%0d", nm, nt / OSR - 1), obs, int'(e[nt / OSR - 1]));
          obs = (nt < nb * OSR) ? int'(e[nt / OSR]) : 0;
        end
      end
      k++;
      step();
    end
    chk({nm, " fd_inside"}, fd_seen, 0);
  endtask

  task automatic frame_end(input string nm);
    chk({nm, " fd_end"}, int'(frame_done), 1);
    chk({nm, " tx_end"}, int'(tx), 1);
    tick = 1'b1;
    step();
    chk({nm, " fd_after"}, int'(frame_done), 0);
  endtask

  task automatic do_frame(input vec_t v);
    tdiv  = v.td;
    phase = 0;
    wait_ready(v.nm);
    din = v.d; parity_mode = v.pm; two_stop = v.two; din_valid = 1'b1; tick = 1'b1;
    step();
    // config changes after the handshake must not reach this frame
    din_valid = 1'b0; din = ~v.d; parity_mode = ~v.pm; two_stop = ~v.two;
    chk({v.nm, " lat_tx"}, int'(tx), 1);
    chk({v.nm, " lat_ready"}, int'(din_ready), 0);
    step();
    chk({v.nm, " ready_after_load"}, int'(din_ready), 1);
    check_bits(v.eb, v.nb, 1'b0, 1'b0, v.nm);
    frame_end(v.nm);
  endtask

  initial begin
    int bad;
    tbl[0] = '{8'h55, 2'b00, 1'b0, 10, 12'h2AA, 1, "t1_55"};
    tbl[1] = '{8'h07, 2'b01, 1'b0, 11, 12'h60E, 2, "even_07"};
    tbl[2] = '{8'h07, 2'b10, 1'b0, 11, 12'h40E, 1, "odd_07"};
    tbl[3] = '{8'h00, 2'b10, 1'b0, 11, 12'h600, 3, "odd_00"};
    tbl[4] = '{8'hFF, 2'b01, 1'b1, 12, 12'hDFE, 1, "two_stop_FF"};
    tbl[5] = '{8'h07, 2'b11, 1'b0, 10, 12'h20E, 2, "pm11_07"};
    tbl[6] = '{8'hA5, 2'b00, 1'b0, 10, 12'h34A, 1, "post_rst_A5"};

    rst = 1'b1; tick = 1'b1; din_valid = 1'b0; din = '0;
    parity_mode = 2'b00; two_stop = 1'b0; brk = 1'b0;
    repeat (3) step();
    chk("rst tx", int'(tx), 1);
    chk("rst ready", int'(din_ready), 1);
    chk("rst busy", int'(tx_busy), 0);
    chk("rst fd", int'(frame_done), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) do_frame(tbl[i]);

    // back-to-back: 0x3C taken during 0xA5's START, no idle gap
    tdiv = 1; phase = 0;
    wait_ready("b2b");
    din = 8'hA5; parity_mode = 2'b00; two_stop = 1'b0; din_valid = 1'b1; tick = 1'b1;
    step();
    din = 8'h3C;
    chk("b2b ready_full", int'(din_ready), 0);
    step();
    check_bits(12'h34A, 10, 1'b0, 1'b1, "b2b_A5");
    check_bits(12'h278, 10, 1'b1, 1'b0, "b2b_3C");
    frame_end("b2b_3C");

    // break in IDLE, word pushed during break, sent after release
    tdiv = 1; phase = 0; tick = 1'b1;
    brk = 1'b1;
    step();
    chk("brk tx", int'(tx), 0);
    chk("brk busy", int'(tx_busy), 1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        din = 8'h3C; parity_mode = 2'b00; two_stop = 1'b0; din_valid = 1'b1;
      end
      if (i == 51) begin
        din_valid = 1'b0;
        chk("brk ready_drop", int'(din_ready), 0);
      end
      if (tx !== 1'b0 || tx_busy !== 1'b1) bad++;
      step();
    end
    chk("brk hold", bad, 0);
    brk = 1'b0;
    step();
    chk("brk idle_tx", int'(tx), 1);
    chk("brk idle_busy", int'(tx_busy), 1);
    step();
    check_bits(12'h278, 10, 1'b0, 1'b0, "brk_3C");
    frame_end("brk_3C");

    // reset during the 4th data bit discards the frame
    tdiv = 1; phase = 0; tick = 1'b1;
    wait_ready("rst_mid");
    din = 8'h55; parity_mode = 2'b00; two_stop = 1'b0; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    repeat (70) step();
    chk("rst_mid pre_tx", int'(tx), 0);
    rst = 1'b1;
    step();
    chk("rst_mid tx", int'(tx), 1);
    chk("rst_mid busy", int'(tx_busy), 0);
    chk("rst_mid ready", int'(din_ready), 1);
    chk("rst_mid fd", int'(frame_done), 0);
    rst = 1'b0;
    bad = 0;
    repeat (200) begin
      step();
      if (frame_done !== 1'b0 || tx !== 1'b1) bad++;
    end
    chk("rst_mid quiet", bad, 0);
    do_frame(tbl[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
